// File: rtl/uart_auth_rx.sv
// uart_auth_rx: 8N1 UART receiver for the BLE command link, followed by the
// authorization FSM that turns 'G' / 'S' commands into the pwr_up enable.
// Every bit period is BAUD_DIV clocks. The start-bit check happens half a bit
// after the falling edge. Data and stop bits are then sampled at bit centres.
module uart_auth_rx #(
    parameter int unsigned BAUD_DIV = 2604,   // clocks per bit, >= 16
    parameter logic [7:0]  GO_CMD   = 8'h47,
    parameter logic [7:0]  STOP_CMD = 8'h53
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    // The counter expires at zero. Loading N-1 therefore gives a period of N clocks.
    localparam logic [11:0] FULL_RELOAD = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_RELOAD = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_WAIT_HI = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        AUTH_OFF       = 2'd0,
        AUTH_PWRD      = 2'd1,
        AUTH_STOP_PEND = 2'd2
    } auth_state_e;

    // Synchronizer and edge detection.
    logic        rx_meta_q;
    logic        rx_sync_q;
    logic        rx_prev_q;
    logic [1:0]  settle_q;
    logic        rx_s;
    logic        fall_s;

    // Receiver datapath.
    rx_state_e   rx_state_q, rx_state_d;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic [8:0]  shreg_q,    shreg_d;
    logic [7:0]  rx_data_q,  rx_data_d;
    logic        rx_rdy_q,   rx_rdy_d;
    logic        frm_err_q,  frm_err_d;
    logic        baud_tick_s;

    // Authorization.
    auth_state_e auth_q, auth_d;
    logic        pwr_up_q, pwr_up_d;
    logic        go_s;
    logic        stop_s;

    assign rx_s = rx_sync_q;

    // A falling edge counts only once the edge history holds real line values.
    // This keeps a line held low through reset from being taken as a start bit.
    assign fall_s      = rx_prev_q & ~rx_s;
    assign baud_tick_s = (baud_cnt_q == 12'd0);

    // Two-flop RX synchronizer, preset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Edge history. It is held low until the preset values have flushed out of the synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q  <= 2'd0;
            rx_prev_q <= 1'b0;
        end else begin
            settle_q  <= (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
            rx_prev_q <= (settle_q == 2'd2) ? rx_s : 1'b0;
        end
    end

    // Receiver next-state: frame sequencing, bit sampling and output pulses.
    always_comb begin
        rx_state_d = rx_state_q;
        baud_cnt_d = baud_tick_s ? baud_cnt_q : baud_cnt_q - 12'd1;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_rdy_d   = 1'b0;
        frm_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (fall_s) begin
                    baud_cnt_d = HALF_RELOAD;
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (baud_tick_s) begin
                    if (rx_s) begin
                        // The line went high again before mid-bit, so treat the edge as a glitch.
                        rx_state_d = RX_IDLE;
                    end else begin
                        baud_cnt_d = FULL_RELOAD;
                        bit_cnt_d  = 4'd0;
                        shreg_d    = {rx_s, shreg_q[8:1]};
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (baud_tick_s) begin
                    baud_cnt_d = FULL_RELOAD;
                    shreg_d    = {rx_s, shreg_q[8:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (baud_tick_s) begin
                    // shreg_q[0] still holds the start bit captured low.
                    // The byte sits above it in shreg_q[8:1].
                    if (rx_s && !shreg_q[0]) begin
                        rx_data_d  = shreg_q[8:1];
                        rx_rdy_d   = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frm_err_d  = 1'b1;
                        rx_state_d = RX_WAIT_HI;
                    end
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            RX_WAIT_HI: begin
                // Wait out a break condition so it is not read as a new start bit.
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_HI;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Receiver state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            baud_cnt_q <= 12'd0;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 9'd0;
            rx_data_q  <= 8'd0;
            rx_rdy_q   <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            rx_rdy_q   <= rx_rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign go_s   = rx_rdy_q && (rx_data_q == GO_CMD);
    assign stop_s = rx_rdy_q && (rx_data_q == STOP_CMD);

    // Authorization next-state. Bytes count only on rx_rdy cycles, while rider_off is checked every cycle.
    always_comb begin
        auth_d = auth_q;
        case (auth_q)
            AUTH_OFF: begin
                if (go_s) begin
                    auth_d = AUTH_PWRD;
                end else begin
                    auth_d = AUTH_OFF;
                end
            end
            AUTH_PWRD: begin
                // A rider stepping off alone never removes power here.
                if (stop_s) begin
                    auth_d = rider_off ? AUTH_OFF : AUTH_STOP_PEND;
                end else begin
                    auth_d = AUTH_PWRD;
                end
            end
            AUTH_STOP_PEND: begin
                // A fresh GO overrides a simultaneous rider_off.
                if (go_s) begin
                    auth_d = AUTH_PWRD;
                end else if (rider_off) begin
                    auth_d = AUTH_OFF;
                end else begin
                    auth_d = AUTH_STOP_PEND;
                end
            end
            default: begin
                auth_d = AUTH_OFF;
            end
        endcase
        pwr_up_d = (auth_d != AUTH_OFF);
    end

    // Authorization state and registered pwr_up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auth_q   <= AUTH_OFF;
            pwr_up_q <= 1'b0;
        end else begin
            auth_q   <= auth_d;
            pwr_up_q <= pwr_up_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;
    assign frm_err = frm_err_q;
    assign pwr_up  = pwr_up_q;

endmodule

// File: tb/tb_uart_auth_rx.sv
// Self-checking bench for uart_auth_rx. It sends serial frames and predicts
// the rx_rdy/frm_err events, their timing window, rx_data and pwr_up from a
// frame-level model of the command protocol.
`timescale 1ns/1ps
module tb_uart_auth_rx;

    localparam int B = 40;                       // short bit time keeps the run small
    localparam logic [7:0] GO  = 8'h47;
    localparam logic [7:0] STP = 8'h53;
    localparam int LAT = (19 * B) / 2 + 3;       // start edge to rx_rdy: 9.5 bits + 3

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       rider_off = 1'b0;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;
    logic       pwr_up;

    uart_auth_rx #(.BAUD_DIV(B), .GO_CMD(GO), .STOP_CMD(STP)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .rider_off(rider_off),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .frm_err(frm_err), .pwr_up(pwr_up)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rdy_cyc = 0;
    bit rnd_rider = 1'b0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         due;
    } ev_t;
    ev_t exp_q[$];

    // Protocol model: 0 = off, 1 = powered, 2 = stop pending.
    int         m_state = 0;
    logic [7:0] m_data = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int auth_next(input int st, input bit rdy, input logic [7:0] b, input bit off);
        if (st == 0) return (rdy && b == GO) ? 1 : 0;
        if (st == 1) return (rdy && b == STP) ? (off ? 0 : 2) : 1;
        if (rdy && b == GO) return 1;
        return off ? 0 : 2;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Compare the DUT against the model every cycle, on the falling edge.
    always @(negedge clk) begin
        ev_t        e;
        bit         rdy_ok;
        logic [7:0] bval;
        rdy_ok = 1'b0;
        bval   = 8'h00;
        if (!rst_n) begin
            check("rst_rx_data", 32'(rx_data), 32'h0);
            check("rst_rx_rdy", 32'(rx_rdy), 32'h0);
            check("rst_frm_err", 32'(frm_err), 32'h0);
            check("rst_pwr_up", 32'(pwr_up), 32'h0);
            exp_q.delete();
            m_state = 0;
            m_data  = 8'h00;
        end else begin
            if (rx_rdy || frm_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse got rdy=%0b frm=%0b want=none (cycle %0d)", rx_rdy, frm_err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'({rx_rdy, frm_err}), e.is_err ? 32'h1 : 32'h2);
                    check("pulse_time", 32'(cyc >= e.due - 1 && cyc <= e.due + 1), 32'h1);
                    if (!e.is_err) begin
                        m_data       = e.data;
                        rdy_ok       = 1'b1;
                        bval         = e.data;
                        last_rdy_cyc = cyc;
                    end
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due + 1) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse got=none want=%s data=%0h due=%0d", exp_q[0].is_err ? "frm_err" : "rx_rdy", exp_q[0].data, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            check("rx_data", 32'(rx_data), 32'(m_data));
            check("pwr_up", 32'(pwr_up), 32'(m_state != 0));
            m_state = auth_next(m_state, rdy_ok, bval, rider_off);
        end
    end

    // Hold RX at v for nbits bit times. It is called at posedge+1 and returns at posedge+1.
    task automatic drive_bit(input logic v, input int nbits);
        RX = v;
        for (int i = 0; i < nbits * B; i++) begin
            @(posedge clk);
            #1;
            if (rnd_rider && $urandom_range(0, 63) == 0) rider_off = ~rider_off;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_stop);
        ev_t e;
        e.is_err = bad_stop;
        e.data   = b;
        e.due    = cyc + LAT;
        exp_q.push_back(e);
        drive_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
        if (bad_stop) begin
            drive_bit(1'b0, 3);
            drive_bit(1'b1, 1);
        end else begin
            drive_bit(1'b1, 1);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         st;
        int         r;
        logic [7:0] b;
        bit         bad;

        // Reset state.
        wait_cycles(3);
        check("reset_pwr_up", 32'(pwr_up), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        rst_n = 1'b1;
        wait_cycles(5);

        // First GO: power up with the expected latency.
        st = cyc;
        send_frame(GO, 1'b0);
        check("go_rx_data", 32'(rx_data), 32'h47);
        check("go_pwr_up", 32'(pwr_up), 32'h1);
        check("go_latency", 32'(last_rdy_cyc - st >= 382 && last_rdy_cyc - st <= 384), 32'h1);

        // STOP with the rider on holds power. rider_off then drops it, and a repeated STOP does nothing.
        send_frame(STP, 1'b0);
        check("stop_pend_pwr", 32'(pwr_up), 32'h1);
        rider_off = 1'b1;
        wait_cycles(2);
        check("rider_off_pwr", 32'(pwr_up), 32'h0);
        send_frame(STP, 1'b0);
        check("stop_in_off", 32'(pwr_up), 32'h0);

        // GO from STOP_PEND resumes PWRD. rider_off alone then has no effect.
        rider_off = 1'b0;
        send_frame(GO, 1'b0);
        send_frame(STP, 1'b0);
        send_frame(GO, 1'b0);
        rider_off = 1'b1;
        wait_cycles(3);
        check("pwrd_rider_off", 32'(pwr_up), 32'h1);
        send_frame(STP, 1'b0);
        check("stop_rider_off", 32'(pwr_up), 32'h0);
        send_frame(8'h41, 1'b0);
        check("other_byte_data", 32'(rx_data), 32'h41);
        check("other_byte_pwr", 32'(pwr_up), 32'h0);

        // Short low glitch: no output. A normal frame is received afterwards.
        RX = 1'b0;
        wait_cycles(6);
        drive_bit(1'b1, 2);
        send_frame(GO, 1'b0);
        check("after_glitch_pwr", 32'(pwr_up), 32'h1);

        // Stop bit held low: frm_err, rx_data unchanged, then recovery.
        send_frame(8'hA5, 1'b1);
        check("frm_data_kept", 32'(rx_data), 32'h47);
        check("frm_pwr_kept", 32'(pwr_up), 32'h1);
        send_frame(GO, 1'b0);

        // Back-to-back stream, then reset in the middle of a fourth byte.
        rider_off = 1'b0;
        send_frame(GO, 1'b0);
        send_frame(STP, 1'b0);
        send_frame(GO, 1'b0);
        check("stream_pwr", 32'(pwr_up), 32'h1);
        drive_bit(1'b0, 1);
        drive_bit(1'b1, 1);
        drive_bit(1'b0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwr", 32'(pwr_up), 32'h0);
        check("async_rst_data", 32'(rx_data), 32'h0);
        check("async_rst_rdy", 32'(rx_rdy), 32'h0);
        wait_cycles(10);
        RX = 1'b1;
        wait_cycles(10);
        rst_n = 1'b1;
        drive_bit(1'b1, 3);
        check("post_rst_data", 32'(rx_data), 32'h0);

        // Randomized traffic, with rider_off toggling at random points.
        rnd_rider = 1'b1;
        for (int n = 0; n < 16; n++) begin
            r   = $urandom_range(0, 9);
            b   = (r < 3) ? GO : (r < 6) ? STP : 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad);
            if (bad || $urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 3));
        end
        rnd_rider = 1'b0;
        drive_bit(1'b1, 2);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
